// File: rtl/lc3_fetch_pkg.sv
// Shared opcode constants, fetch FSM states and the offset sign-extension helper.
package lc3_fetch_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_state_t;

  // Sign-extend the low w bits of val to 32 bits; callers truncate to their own width.
  function automatic logic [31:0] sext(input logic [31:0] val, input int unsigned w);
    logic signed [31:0] t;
    t = val << (32 - w);
    return t >>> (32 - w);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead prefetch FIFO with synchronous flush; head is visible the cycle after the push.
// Push while full is accepted only together with a pop; pop while empty is ignored.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [W-1:0]           i_dat,
  input  logic                   i_pop,
  output logic                   o_vld,
  output logic [W-1:0]           o_dat,
  output logic [$clog2(DEPTH):0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign w_pop_ok  = i_pop && (r_cnt != '0);
  assign w_push_ok = i_push && ((r_cnt != CW'(DEPTH)) || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wp] <= i_dat;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop_ok) r_rp <= r_rp + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_vld = (r_cnt != '0);
  assign o_dat = r_mem[r_rp];
  assign o_cnt = r_cnt;

endmodule

// File: rtl/lc3_fetch_pq.sv
// LC-3 fetch unit: single-outstanding memory reads into a show-ahead prefetch queue, flushed on taken BR/JMP.
// Requests issue only with a free slot reserved; FETCH_STATS_EN adds saturating push/flush counters.
module lc3_fetch_pq
  import lc3_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                OFF_W    = 9,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              wea_out,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              resolve_valid,
  input  logic [ADDR_W-1:0] resolve_pc,
  input  logic [3:0]        opCode_in,
  input  logic [OFF_W-1:0]  offset_in,
  input  logic [ADDR_W-1:0] reg_in,
  input  logic [2:0]        br_nzp,
  input  logic [2:0]        result_nzp,
`ifdef FETCH_STATS_EN
  output logic [31:0]       fetch_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic [ADDR_W-1:0] pc
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      r_state;
  fetch_state_t      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_target;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic [CW-1:0]     w_cnt;
  logic [CW-1:0]     w_cnt_nxt;

  assign w_taken = resolve_valid &&
                   (((opCode_in == OP_BR) && |(br_nzp & result_nzp)) || (opCode_in == OP_JMP));
  assign w_target = (opCode_in == OP_JMP) ? reg_in
                  : resolve_pc + ADDR_W'(sext(32'(offset_in), OFF_W));

  assign w_push    = (r_state == REQ) && mem_ack && !w_taken;
  assign w_pop     = instr_ready && instr_valid && !w_taken;
  assign w_full    = (w_cnt == CW'(DEPTH));
  assign w_cnt_nxt = w_cnt + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      IDLE: if (fetch_start && !w_full) w_state_nxt = REQ;
      REQ: begin
        if (w_taken) begin
          w_state_nxt = mem_ack ? IDLE : DRAIN;
        end else if (mem_ack) begin
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = (fetch_start && (w_cnt_nxt < CW'(DEPTH))) ? REQ : IDLE;
        end
      end
      DRAIN: if (mem_ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_taken) w_pc_nxt = w_target;
  end

  // The address register latches only when a request is (re)issued, so it holds through DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_state_nxt == REQ) r_addr <= w_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .W    (DATA_W + ADDR_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_flush(w_taken),
    .i_push (w_push),
    .i_dat  ({mem_rdata, r_addr}),
    .i_pop  (w_pop),
    .o_vld  (instr_valid),
    .o_dat  ({instr_out, instr_pc}),
    .o_cnt  (w_cnt)
  );

  assign mem_req  = (r_state == REQ) || (r_state == DRAIN);
  assign mem_addr = r_addr;
  assign wea_out  = 1'b0;
  assign pc       = r_pc;

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_push && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_lc3_fetch_pq.sv
// Directed bench for lc3_fetch_pq: reset, streaming, full queue, BR/JMP redirects, PC wrap, mid-request reset.
module tb_lc3_fetch_pq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        resolve_valid = 1'b0;
  logic [15:0] resolve_pc = '0;
  logic [3:0]  opCode_in = '0;
  logic [8:0]  offset_in = '0;
  logic [15:0] reg_in = '0;
  logic [2:0]  br_nzp = '0;
  logic [2:0]  result_nzp = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        wea_out;
  logic        instr_valid;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic [15:0] pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] flush_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  lc3_fetch_pq dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .wea_out(wea_out),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .opCode_in(opCode_in),
    .offset_in(offset_in), .reg_in(reg_in), .br_nzp(br_nzp), .result_nzp(result_nzp),
`ifdef FETCH_STATS_EN
    .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
    .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_req === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  // Acknowledge the outstanding request one cycle later with data = addr + 0x1000.
  task automatic serve(output bit ok);
    wait_req(ok);
    if (ok) begin
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = mem_addr + 16'h1000;
      @(negedge clk);
      mem_ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fetch_start = 1'b0; instr_ready = 1'b0; mem_ack = 1'b0; resolve_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (pc !== 16'h0000) $display("FAIL reset_pc got=%h exp=0000", pc); else n_pass++;
    n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else n_pass++;
    n_total++; if (wea_out !== 1'b0) $display("FAIL reset_wea got=%b exp=0", wea_out); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", instr_valid); else n_pass++;
    n_total++; if (mem_addr !== 16'h0000) $display("FAIL reset_addr got=%h exp=0000", mem_addr); else n_pass++;
    n_total++; if (instr_out !== 16'h0000) $display("FAIL reset_instr got=%h exp=0000", instr_out); else n_pass++;
  endtask

  task automatic test_stream();
    bit ok;
    do_reset();
    instr_ready = 1'b1;
    fetch_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(ok);
      n_total++; if (!ok) $display("FAIL stream_req_timeout idx=%0d got=no_req exp=req", i); else n_pass++;
      n_total++; if (instr_valid !== 1'b1) $display("FAIL stream_valid idx=%0d got=%b exp=1", i, instr_valid); else n_pass++;
      n_total++; if (instr_pc !== 16'(i)) $display("FAIL stream_pc idx=%0d got=%h exp=%h", i, instr_pc, 16'(i)); else n_pass++;
      n_total++; if (instr_out !== 16'h1000 + 16'(i)) $display("FAIL stream_instr idx=%0d got=%h exp=%h", i, instr_out, 16'h1000 + 16'(i)); else n_pass++;
    end
  endtask

  task automatic test_full();
    bit ok;
    int hi;
    do_reset();
    fetch_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(ok);
      n_total++; if (!ok) $display("FAIL full_req_timeout idx=%0d got=no_req exp=req", i); else n_pass++;
    end
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req !== 1'b0) hi++;
      @(negedge clk);
    end
    n_total++; if (hi != 0) $display("FAIL full_no_req got=%0d exp=0", hi); else n_pass++;
    n_total++; if (pc !== 16'h0004) $display("FAIL full_pc got=%h exp=0004", pc); else n_pass++;
    n_total++; if (instr_pc !== 16'h0000) $display("FAIL full_head got=%h exp=0000", instr_pc); else n_pass++;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    wait_req(ok);
    n_total++; if (!ok) $display("FAIL pop_req_timeout got=no_req exp=req"); else n_pass++;
    n_total++; if (mem_addr !== 16'h0004) $display("FAIL pop_addr got=%h exp=0004", mem_addr); else n_pass++;
    n_total++; if (instr_pc !== 16'h0001) $display("FAIL pop_head got=%h exp=0001", instr_pc); else n_pass++;
    serve(ok);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req !== 1'b0) hi++;
      @(negedge clk);
    end
    n_total++; if (hi != 0) $display("FAIL refill_single_req got=%0d exp=0", hi); else n_pass++;
    n_total++; if (pc !== 16'h0005) $display("FAIL refill_pc got=%h exp=0005", pc); else n_pass++;
  endtask

  task automatic test_branch();
    bit ok1, ok2;
    do_reset();
    fetch_start = 1'b1;
    serve(ok1);
    fetch_start = 1'b0;
    serve(ok2);
    n_total++; if (!(ok1 && ok2)) $display("FAIL br_prefill got=%b%b exp=11", ok1, ok2); else n_pass++;
    n_total++; if (instr_valid !== 1'b1) $display("FAIL br_pre_valid got=%b exp=1", instr_valid); else n_pass++;
    resolve_valid = 1'b1; opCode_in = 4'b0000; resolve_pc = 16'h0005;
    offset_in = 9'h1FE; br_nzp = 3'b011; result_nzp = 3'b010;
    @(negedge clk);
    resolve_valid = 1'b0;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL br_flush got=%b exp=0", instr_valid); else n_pass++;
    n_total++; if (pc !== 16'h0003) $display("FAIL br_pc got=%h exp=0003", pc); else n_pass++;
    fetch_start = 1'b1;
    wait_req(ok1);
    n_total++; if (mem_addr !== 16'h0003 || !ok1) $display("FAIL br_addr got=%h exp=0003", mem_addr); else n_pass++;
    fetch_start = 1'b0;
    serve(ok1);
    n_total++; if (instr_out !== 16'h1003) $display("FAIL br_instr got=%h exp=1003", instr_out); else n_pass++;
    resolve_valid = 1'b1; result_nzp = 3'b100;
    @(negedge clk);
    resolve_valid = 1'b0;
    n_total++; if (pc !== 16'h0004) $display("FAIL br_nt_pc got=%h exp=0004", pc); else n_pass++;
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0003) $display("FAIL br_nt_queue got=%b/%h exp=1/0003", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_jmp_drain();
    bit ok;
    fetch_start = 1'b1;
    wait_req(ok);
    n_total++; if (mem_addr !== 16'h0004 || !ok) $display("FAIL jmp_pre_addr got=%h exp=0004", mem_addr); else n_pass++;
    resolve_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'h3000;
    @(negedge clk);
    resolve_valid = 1'b0;
    n_total++; if (mem_req !== 1'b1 || mem_addr !== 16'h0004) $display("FAIL drain_hold got=%b/%h exp=1/0004", mem_req, mem_addr); else n_pass++;
    n_total++; if (pc !== 16'h3000) $display("FAIL jmp_pc got=%h exp=3000", pc); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL jmp_flush got=%b exp=0", instr_valid); else n_pass++;
    serve(ok);
    n_total++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL drain_discard got=%b/%b exp=0/0", instr_valid, mem_req); else n_pass++;
    wait_req(ok);
    n_total++; if (mem_addr !== 16'h3000 || !ok) $display("FAIL jmp_target_addr got=%h exp=3000", mem_addr); else n_pass++;
    fetch_start = 1'b0;
    serve(ok);
    n_total++; if (instr_pc !== 16'h3000 || instr_out !== 16'h4000) $display("FAIL jmp_instr got=%h/%h exp=3000/4000", instr_pc, instr_out); else n_pass++;
  endtask

  task automatic test_wrap_reset();
    bit ok;
    resolve_valid = 1'b1; opCode_in = 4'b1100; reg_in = 16'hFFFF;
    @(negedge clk);
    resolve_valid = 1'b0;
    n_total++; if (pc !== 16'hFFFF) $display("FAIL wrap_jmp_pc got=%h exp=ffff", pc); else n_pass++;
    fetch_start = 1'b1;
    serve(ok);
    n_total++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1) $display("FAIL wrap_addr got=%b/%h exp=1/0000", mem_req, mem_addr); else n_pass++;
    n_total++; if (instr_pc !== 16'hFFFF || instr_out !== 16'h0FFF) $display("FAIL wrap_instr got=%h/%h exp=ffff/0fff", instr_pc, instr_out); else n_pass++;
    serve(ok);
    n_total++; if (pc !== 16'h0001 || mem_req !== 1'b1) $display("FAIL prereset_state got=%b/%h exp=1/0001", mem_req, pc); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if (pc !== 16'h0000) $display("FAIL arst_pc got=%h exp=0000", pc); else n_pass++;
    n_total++; if (mem_req !== 1'b0 || mem_addr !== 16'h0000) $display("FAIL arst_req got=%b/%h exp=0/0000", mem_req, mem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0 || instr_out !== 16'h0 || instr_pc !== 16'h0) $display("FAIL arst_queue got=%b/%h/%h exp=0/0000/0000", instr_valid, instr_out, instr_pc); else n_pass++;
    fetch_start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    @(negedge clk);
    n_total++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc !== 16'h0000) $display("FAIL late_ack got=%b/%b/%h exp=0/0/0000", instr_valid, mem_req, pc); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_branch();
    test_jmp_drain();
    test_wrap_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
